// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry register, one sum bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a `sub` input that selects a - b (two's complement).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cout_q, cout_d;

  logic             accept;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Handshake: start is taken on any rising edge where busy is low (IDLE or the
  // done cycle); while busy is high start is ignored. done pulses for one cycle
  // when y/cout hold a new result, and y/cout stay stable until the next done.
  assign accept = start && (state_q != RUN);

  assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  // Current bit enters at the MSB; on the last bit this is the complete sum.
  assign sum_shift = {fa_s, sum_sr_q};

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    y_d      = y_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift[WIDTH-1:1];
        carry_d  = fa_c;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
          y_d     = sum_shift;
          cout_d  = fa_c;
        end
      end
      DONE: begin
        state_d = accept ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b_load;
      carry_d = carry_load;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      y_q      <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      y_q      <= y_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign y         = y_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// checked every cycle against a timeline model of start -> result after WIDTH edges.
module tb_serial_adder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] y;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Unsigned add, or a - b with cout meaning "no borrow".
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
    logic [W-1:0] diff;
    if (rs) begin
      diff = ra - rb;
      return {(ra >= rb), diff};
    end
    return {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
  endfunction

  // ---------------- behavioural model ----------------
  logic         m_active = 1'b0;
  logic         m_done   = 1'b0;
  logic         m_cout   = 1'b0;
  logic [W-1:0] m_y      = '0;
  logic [W:0]   m_res    = '0;
  int           m_left   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_cout   <= 1'b0;
      m_y      <= '0;
      m_left   <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_active <= 1'b0;
          m_y      <= m_res[W-1:0];
          m_cout   <= m_res[W];
          m_done   <= 1'b1;
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_left   <= W;
        m_res    <= ref_result(a, b, cin, sub);
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("y",    32'(y),    32'(m_y));
    check("cout", 32'(cout), 32'(m_cout));
  end

  // ---------------- driver ----------------
  // Drives one operation (start sampled at the next rising edge E0) and checks
  // done latency, busy length and the result. poke_at>0 re-pulses start with
  // junk operands so that it is sampled at edge E(poke_at), while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input int poke_at,
                        input logic [W-1:0] exp_y, input logic exp_cout, input string tag);
    int  lat;
    int  busy_n;
    bit  seen;
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
    busy_n = busy ? 1 : 0;
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 3 * W; n++) begin
      if (poke_at != 0 && n == poke_at) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat = n;
        break;
      end
      if (busy) busy_n++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, "_y"}, 32'(y), 32'(exp_y));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    logic [W:0]   r;
    int           gap, poke;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y",    32'(y),    32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    @(negedge clk);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 8'h10, 1'b0, "basic");

    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, "wrap1");
    repeat (3) begin
      @(negedge clk);
      check("wrap_hold_y", 32'(y), 32'h00);
    end
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b1, "wrap2");

    @(negedge clk);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 8'h46, 1'b0, "ignore_start");

    @(negedge clk);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 8'h10, 1'b0, "b2b_first");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 8'h00, 1'b1, "b2b_second");
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 8'h46, 1'b0, "b2b_third");

    // Reset in the middle of an operation: outputs clear with no clock edge.
    @(negedge clk);
    a = 8'h55; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_y",    32'(y),    32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h03, 8'h04, 1'b1, 1'b0, 0, 8'h08, 1'b0, "after_rst");

`ifdef SERIAL_ADDER_SUB_EN
    @(negedge clk);
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 8'hFE, 1'b0, "sub_borrow");
    @(negedge clk);
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 0, 8'h02, 1'b1, "sub_noborrow");
`endif

    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      poke = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
      r = ref_result(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, poke, r[W-1:0], r[W], "rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that produces one sum bit per clock from a single full-adder cell plus a carry register. It sits directly upstream of the combinational full-adder stage. It sequences operand bits and the registered carry into that cell, then collects its sum/carry outputs into a parallel result. It is the area-cheap alternative to a ripple-carry chain, and is reused by later multi-cycle arithmetic blocks.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on a rising edge.
- a  input  WIDTH  operand A; captured only on an accepted start.
- b  input  WIDTH  operand B; captured only on an accepted start.
- cin  input  1  carry-in; captured only on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking a new valid result.
- y  output  WIDTH  sum result; holds its value until the next completion.
- cout  output  1  final carry-out; holds its value until the next completion.

## Operation
- Reset, asynchronous: state = IDLE; busy, done, y, cout, carry register, bit counter and shift registers all return to 0.
- FSM states:
  - IDLE to RUN on start.
  - RUN stays in RUN while the counter is below WIDTH-1; on the last bit it goes to DONE.
  - DONE to RUN on start; otherwise DONE to IDLE.
- Accepted start (state is IDLE or DONE):
  - Load a_sr ← a and b_sr ← b.
  - Load carry ← cin and count ← 0.
- Each RUN cycle:
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - c = majority(a_sr[0], b_sr[0], carry).
  - a_sr and b_sr shift right by one.
  - s shifts into the MSB of an internal sum register, which shifts right.
  - carry ← c and count ← count+1.
- On the last RUN cycle:
  - y ← the final sum register contents, including this cycle's bit.
  - cout ← c.
- start while in RUN is ignored: no reload and no error flag.
- y and cout change only at completion; they are never visible mid-operation.
- Widths:
  - Counter is $clog2(WIDTH) bits.
  - No overflow flag; cout is the only carry/overflow indication. It follows unsigned semantics.

## Timing
- Start sampled at edge E0.
- busy is high from after E0 through the cycle following edge E(WIDTH-1).
- y, cout and done update at edge E(WIDTH). done is high for exactly one cycle after E(WIDTH), and busy is low in that cycle.
- Latency: WIDTH+1 rising edges from the start-sample edge to the done-visible edge, inclusive of E0.
- Back-to-back operation: start asserted during the done cycle is accepted. Throughput is one result per WIDTH+1 cycles.
- rst asserted mid-RUN:
  - The operation is aborted immediately and no done is produced.
  - y and cout clear to 0.
  - The first edge after rst deasserts sees state IDLE.
- rst deasserting in the same cycle start is high: start is sampled normally at the first edge after release.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds port sub, input, 1 bit, sampled together with start.
  - If sub=1 at an accepted start: b_sr ← ~b and carry ← 1, with cin ignored. The result is y = a − b mod 2^WIDTH, and cout = 1 means no borrow (a ≥ b unsigned).
  - If sub=0: behaviour is identical to the add-only build.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port; the block is add-only.
  - Timing is the same in both builds.

## Test plan
- Basic add, WIDTH=8: a=0x0F, b=0x01, cin=0, start for one cycle → done pulse exactly 9 edges after the start edge (inclusive), y=0x10, cout=0. busy is high for 8 cycles.
- Carry wrap: a=0xFF, b=0x01, cin=0 → y=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → y=0xFF, cout=1. Check that y holds 0x00 until the second done.
- Start ignored while busy: start a=0x12, b=0x34; pulse start with a=0xAA, b=0xAA three cycles later → single done, y=0x46, no extra done or busy extension.
- Back-to-back: assert start in the done cycle with a=0x80, b=0x80, cin=0 → second done 9 edges later, y=0x00, cout=1. There are no idle cycles between operations.
- Reset mid-operation: a=0x55, b=0x55, cin=0; assert rst asynchronously after 4 RUN cycles → busy, done, y, cout go to 0 immediately without a clock edge. No done follows, and the next start operates normally.
- With SERIAL_ADDER_SUB_EN, sub=1: a=0x05, b=0x07 → y=0xFE, cout=0. Then a=0x07, b=0x05 → y=0x02, cout=1.
